// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the round-robin SRAM arbiter.
// The requester id is sized for the largest legal requester count (4).
package sram_arb_pkg;

    localparam int RD_LAT  = 3;
    localparam int MAX_REQ = 4;
    localparam int ID_W    = (MAX_REQ > 2) ? $clog2(MAX_REQ) : 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } pipe_entry_t;

    // Successor of a requester id, wrapping at n so the pointer never leaves 0..n-1.
    function automatic req_id_t next_ptr(input req_id_t id, input int n);
        if (int'(id) >= n - 1) begin
            return '0;
        end
        return id + req_id_t'(1);
    endfunction

endpackage

// File: rtl/sram_wrapper.sv
// Single-port SRAM macro model with a write-data capture register and a read-data output flop.
// Read latency from an issued request is two edges; writes commit on the issue edge.
module sram_wrapper #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              wmode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] macro_q;

    // wdata arrives one cycle ahead of addr/en, so it is captured here to line up with the issue.
    always_ff @(posedge clk) begin
        wdata_q <= wdata;
        if (en) begin
            if (wmode) begin
                mem[addr] <= wdata_q;
            end else begin
                macro_q <= mem[addr];
            end
        end
        rdata <= macro_q;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM among NUM_REQ requesters, one grant per cycle,
// with a fixed-latency response pipeline that routes read data back in grant order.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int NUM_REQ = 2
) (
    input  logic                            RW0_clk,
    input  logic                            RW0_rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_wmode,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            idle
);

    req_id_t           rr_ptr;
    logic              grant;
    req_id_t           grant_id;
    logic              wmode_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    logic              iss_valid;
    logic              iss_wmode;
    logic [ADDR_W-1:0] iss_addr;
    pipe_entry_t       pipe [RD_LAT];

    // Pick the valid requester with the smallest upward distance from rr_ptr.
    always_comb begin
        int best_d;
        int d;
        grant    = 1'b0;
        grant_id = '0;
        best_d   = NUM_REQ;
        d        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = i - int'(rr_ptr);
            if (d < 0) begin
                d = d + NUM_REQ;
            end
            if (req_valid[i] && (d < best_d)) begin
                best_d   = d;
                grant_id = req_id_t'(i);
                grant    = 1'b1;
            end
        end
        if (RW0_rst) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        wmode_mux = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (int'(grant_id) == i)) begin
                req_ready[i] = 1'b1;
                wmode_mux    = req_wmode[i];
                addr_mux     = req_addr[i];
                wdata_mux    = req_wdata[i];
            end
        end
    end

    // Only reads enter the response pipeline; writes live in the issue register alone.
    always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
            rr_ptr    <= '0;
            iss_valid <= 1'b0;
            iss_wmode <= 1'b0;
            iss_addr  <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            if (grant) begin
                rr_ptr <= next_ptr(grant_id, NUM_REQ);
            end
            iss_valid <= grant;
            iss_wmode <= wmode_mux;
            iss_addr  <= addr_mux;
            pipe[0]   <= '{valid: grant && !wmode_mux, id: grant_id};
            for (int s = 1; s < RD_LAT; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pipe[RD_LAT-1].valid && (int'(pipe[RD_LAT-1].id) == i)) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    always_comb begin
        idle = !iss_valid;
        for (int s = 0; s < RD_LAT; s++) begin
            if (pipe[s].valid) begin
                idle = 1'b0;
            end
        end
    end

    sram_wrapper #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_sram (
        .clk  (RW0_clk),
        .en   (iss_valid),
        .wmode(iss_wmode),
        .addr (iss_addr),
        .wdata(wdata_mux),
        .rdata(rsp_rdata)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a 2-requester instance checked against a behavioural model,
// plus a 3-requester instance for pointer wrap-around on a non-power-of-2 count.
module tb_sram_arbiter;

    logic clk;

    logic             rst;
    logic [1:0]       valid;
    logic [1:0]       ready;
    logic [1:0]       wmode;
    logic [1:0][3:0]  addr;
    logic [1:0][15:0] wdata;
    logic [1:0]       rsp;
    logic [15:0]      rdata;
    logic             idle;

    logic             rst3;
    logic [2:0]       valid3;
    logic [2:0]       ready3;
    logic [2:0]       wmode3;
    logic [2:0][3:0]  addr3;
    logic [2:0][15:0] wdata3;
    logic [2:0]       rsp3;
    logic [15:0]      rdata3;
    logic             idle3;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state for the 2-requester instance.
    int          cyc = 0;
    int          m_ptr = 0;
    logic [15:0] mem [16];
    bit          mem_known [16];
    bit          due_v [8];
    int          due_id [8];
    logic [15:0] due_data [8];
    bit          due_known [8];
    int          last_rd = -100;
    int          last_wr = -100;

    logic [1:0]  exp_ready, exp_rsp, obs_ready, obs_rsp;
    logic [15:0] exp_data, obs_data;
    bit          exp_known;
    logic        exp_idle, obs_idle;
    logic [2:0]  obs3_ready;

    sram_arbiter #(.ADDR_W(4), .DATA_W(16), .NUM_REQ(2)) u_dut2 (
        .RW0_clk(clk), .RW0_rst(rst), .req_valid(valid), .req_ready(ready),
        .req_wmode(wmode), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rsp), .rsp_rdata(rdata), .idle(idle)
    );

    sram_arbiter #(.ADDR_W(4), .DATA_W(16), .NUM_REQ(3)) u_dut3 (
        .RW0_clk(clk), .RW0_rst(rst3), .req_valid(valid3), .req_ready(ready3),
        .req_wmode(wmode3), .req_addr(addr3), .req_wdata(wdata3),
        .rsp_valid(rsp3), .rsp_rdata(rdata3), .idle(idle3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: predict from the model, sample at the falling edge, advance the model.
    task automatic tick();
        int g;
        int j;
        int s;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                j = (m_ptr + k) % 2;
                if (g < 0 && valid[j]) g = j;
            end
        end
        exp_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
        s = cyc % 8;
        exp_rsp   = due_v[s] ? 2'(1 << due_id[s]) : 2'b00;
        exp_data  = due_data[s];
        exp_known = due_known[s];
        exp_idle  = !((cyc - last_rd) >= 1 && (cyc - last_rd) <= 3) && ((cyc - last_wr) != 1);
        @(negedge clk);
        obs_ready  = ready;
        obs_rsp    = rsp;
        obs_data   = rdata;
        obs_idle   = idle;
        obs3_ready = ready3;
        due_v[s] = 1'b0;
        if (rst) begin
            for (int k = 0; k < 8; k++) due_v[k] = 1'b0;
            m_ptr   = 0;
            last_rd = -100;
            last_wr = -100;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % 2;
            if (wmode[g]) begin
                mem[addr[g]]       = wdata[g];
                mem_known[addr[g]] = 1'b1;
                last_wr = cyc;
            end else begin
                due_v[(cyc + 3) % 8]     = 1'b1;
                due_id[(cyc + 3) % 8]    = g;
                due_data[(cyc + 3) % 8]  = mem[addr[g]];
                due_known[(cyc + 3) % 8] = mem_known[addr[g]];
                last_rd = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        valid = 2'b11; wmode = 2'b00; valid3 = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (obs_ready !== 2'b00) begin
                n_err++;
                $display("[TB] FAIL reset_ready: got %b expected 00", obs_ready);
            end
            n_vec++;
            if (obs3_ready !== 3'b000) begin
                n_err++;
                $display("[TB] FAIL reset_ready3: got %b expected 000", obs3_ready);
            end
        end
        rst = 1'b0; rst3 = 1'b0;
        valid = 2'b00; valid3 = 3'b000;
        tick();
        n_vec++;
        if (obs_rsp !== 2'b00 || obs_idle !== 1'b1 || obs_ready !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL post_reset: got rsp=%b idle=%b ready=%b expected rsp=00 idle=1 ready=00",
                     obs_rsp, obs_idle, obs_ready);
        end
    endtask

    task automatic test_single_write_read();
        logic [1:0] e_rsp;
        valid = 2'b01; wmode = 2'b01; addr[0] = 4'd3; wdata[0] = 16'hBEEF;
        tick();
        n_vec++;
        if (obs_ready !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL write_grant: got %b expected 01", obs_ready);
        end
        wmode = 2'b00; wdata[0] = 16'h0000;
        tick();
        n_vec++;
        if (obs_ready !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL read_grant: got %b expected 01", obs_ready);
        end
        valid = 2'b00;
        for (int t = 1; t <= 4; t++) begin
            tick();
            e_rsp = (t == 3) ? 2'b01 : 2'b00;
            n_vec++;
            if (obs_rsp !== e_rsp) begin
                n_err++;
                $display("[TB] FAIL single_rsp_valid G+%0d: got %b expected %b", t, obs_rsp, e_rsp);
            end
            if (t == 3) begin
                n_vec++;
                if (obs_data !== 16'hBEEF) begin
                    n_err++;
                    $display("[TB] FAIL single_rdata: got %h expected beef", obs_data);
                end
            end
            n_vec++;
            if (obs_idle !== (t == 4)) begin
                n_err++;
                $display("[TB] FAIL idle_track G+%0d: got %b expected %b", t, obs_idle, (t == 4));
            end
        end
    endtask

    task automatic test_contention();
        int cnt0;
        int cnt1;
        logic [1:0] e;
        cnt0 = 0; cnt1 = 0;
        rst = 1'b1; valid = 2'b11; wmode = 2'b11;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            addr[0] = 4'($urandom_range(0, 15)); addr[1] = 4'($urandom_range(0, 15));
            wdata[0] = 16'($urandom); wdata[1] = 16'($urandom);
            tick();
            e = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_vec++;
            if (obs_ready !== e) begin
                n_err++;
                $display("[TB] FAIL contention_grant %0d: got %b expected %b", k, obs_ready, e);
            end
            if (obs_ready === 2'b01) cnt0++;
            if (obs_ready === 2'b10) cnt1++;
        end
        n_vec++;
        if (cnt0 != 10 || cnt1 != 10) begin
            n_err++;
            $display("[TB] FAIL contention_share: got %0d/%0d expected 10/10", cnt0, cnt1);
        end
        valid = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] e_data;
        valid = 2'b10; wmode = 2'b10;
        for (int a = 0; a < 16; a++) begin
            addr[1] = 4'(a); wdata[1] = 16'(a * 16'h0101);
            tick();
        end
        valid = 2'b00;
        tick();
        wmode = 2'b00;
        for (int t = 0; t < 20; t++) begin
            valid = (t < 16) ? 2'b01 : 2'b00;
            addr[0] = 4'(t);
            tick();
            if (t < 16) begin
                n_vec++;
                if (obs_ready !== 2'b01) begin
                    n_err++;
                    $display("[TB] FAIL b2b_grant %0d: got %b expected 01", t, obs_ready);
                end
            end
            if (t >= 3 && t < 19) begin
                e_data = 16'((t - 3) * 16'h0101);
                n_vec++;
                if (obs_rsp !== 2'b01 || obs_data !== e_data) begin
                    n_err++;
                    $display("[TB] FAIL b2b_rsp %0d: got valid=%b data=%h expected valid=01 data=%h",
                             t - 3, obs_rsp, obs_data, e_data);
                end
            end else begin
                n_vec++;
                if (obs_rsp !== 2'b00) begin
                    n_err++;
                    $display("[TB] FAIL b2b_quiet %0d: got %b expected 00", t, obs_rsp);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        valid = 2'b01; wmode = 2'b00; addr[0] = 4'd5;
        tick();
        valid = 2'b00; rst = 1'b1;
        tick();
        n_vec++;
        if (obs_rsp !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL midflight_rsp G+1: got %b expected 00", obs_rsp);
        end
        rst = 1'b0;
        for (int t = 2; t <= 4; t++) begin
            tick();
            n_vec++;
            if (obs_rsp !== 2'b00) begin
                n_err++;
                $display("[TB] FAIL midflight_rsp G+%0d: got %b expected 00", t, obs_rsp);
            end
            if (t == 2) begin
                n_vec++;
                if (obs_idle !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL midflight_idle: got %b expected 1", obs_idle);
                end
            end
        end
    endtask

    task automatic test_wrap3();
        logic [2:0] seq [6];
        seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        wmode3 = 3'b111; addr3 = '0; wdata3 = '0;
        valid3 = 3'b010;
        tick();
        n_vec++;
        if (obs3_ready !== 3'b010) begin
            n_err++;
            $display("[TB] FAIL wrap3_setup: got %b expected 010", obs3_ready);
        end
        valid3 = 3'b101;
        tick();
        n_vec++;
        if (obs3_ready !== 3'b100) begin
            n_err++;
            $display("[TB] FAIL wrap3_first: got %b expected 100", obs3_ready);
        end
        tick();
        n_vec++;
        if (obs3_ready !== 3'b001) begin
            n_err++;
            $display("[TB] FAIL wrap3_second: got %b expected 001", obs3_ready);
        end
        valid3 = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if (obs3_ready !== seq[k]) begin
                n_err++;
                $display("[TB] FAIL wrap3_rotate %0d: got %b expected %b", k, obs3_ready, seq[k]);
            end
        end
        valid3 = 3'b000;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            valid = 2'($urandom_range(0, 3));
            wmode = 2'($urandom_range(0, 3));
            addr[0] = 4'($urandom_range(0, 15)); addr[1] = 4'($urandom_range(0, 15));
            wdata[0] = 16'($urandom); wdata[1] = 16'($urandom);
            tick();
            n_vec++;
            if (obs_ready !== exp_ready) begin
                n_err++;
                $display("[TB] FAIL rand_ready %0d: got %b expected %b", k, obs_ready, exp_ready);
            end
            n_vec++;
            if (obs_rsp !== exp_rsp) begin
                n_err++;
                $display("[TB] FAIL rand_rsp_valid %0d: got %b expected %b", k, obs_rsp, exp_rsp);
            end
            if (exp_rsp != 2'b00 && exp_known) begin
                n_vec++;
                if (obs_data !== exp_data) begin
                    n_err++;
                    $display("[TB] FAIL rand_rdata %0d: got %h expected %h", k, obs_data, exp_data);
                end
            end
            n_vec++;
            if (obs_idle !== exp_idle) begin
                n_err++;
                $display("[TB] FAIL rand_idle %0d: got %b expected %b", k, obs_idle, exp_idle);
            end
        end
        valid = 2'b00;
        for (int k = 0; k < 4; k++) tick();
    endtask

    initial begin
        rst = 1'b1; valid = '0; wmode = '0; addr = '0; wdata = '0;
        rst3 = 1'b1; valid3 = '0; wmode3 = '0; addr3 = '0; wdata3 = '0;
        for (int a = 0; a < 16; a++) begin
            mem[a] = '0;
            mem_known[a] = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            due_v[k] = 1'b0; due_id[k] = 0; due_data[k] = '0; due_known[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_write_read();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        test_wrap3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ADDR_W, SRAM_ADDR_W (4): word address width.
- DATA_W, SRAM_DATA_W (16): data width.
- NUM_REQ, 2: number of requesters, legal range 2..4.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- RW0_clk, in, 1: sole clock; all logic is on its rising edge.
- RW0_rst, in, 1: synchronous active-high reset.
- req_valid, in, NUM_REQ: request present, one bit per requester.
- req_ready, out, NUM_REQ: request accepted this cycle.
- req_wmode, in, NUM_REQ: 1 = write, 0 = read.
- req_addr, in, NUM_REQ x ADDR_W: request address.
- req_wdata, in, NUM_REQ x DATA_W: request write data.
- rsp_valid, out, NUM_REQ: read data valid for this requester.
- rsp_rdata, out, DATA_W: read data, shared by all requesters.
- idle, out, 1: no request in flight.

Function
REQ-003 A request SHALL be accepted ("granted") in cycle G when req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high per cycle.

REQ-004 Arbitration SHALL be round-robin:
- req_ready[i] is combinationally high for the first valid requester at or after pointer rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
- On a grant to requester i, rr_ptr SHALL become (i+1) mod NUM_REQ on the next edge.
- Without a grant, rr_ptr SHALL hold.

REQ-005 The block SHALL accept one request per cycle, back-to-back, with no bubbles; there SHALL be no backpressure on responses.

REQ-006 The block SHALL instantiate one sram_wrapper and drive it as follows:
- wdata: the granted requester's req_wdata in cycle G (combinational mux).
- addr, en=1, wmode: registered copies of the granted request, driven in cycle G+1.
- en=0 in any cycle with no issue.

REQ-007 A write granted in cycle G SHALL commit at the edge ending cycle G+1.

REQ-008 A read granted in cycle G SHALL assert rsp_valid[i] for exactly one cycle, cycle G+3, with rsp_rdata carrying the stored word. The 3-cycle latency is fixed: 1 cycle issue register, 1 cycle macro, 1 cycle wrapper output flop.

REQ-009 Writes SHALL produce no response.

REQ-010 A read granted in cycle G+1 or later to the address of a write granted in cycle G SHALL return the new data.

REQ-011 Response routing SHALL use a 3-stage {valid, requester-id} shift pipeline. Responses SHALL return in grant order, and the rsp_valid bits SHALL be one-hot or zero.

REQ-012 rsp_rdata is don't-care when rsp_valid is zero; the bench SHALL NOT check it then.

REQ-013 idle SHALL be high when the issue register and all pipeline stages hold no valid entry.

REQ-014 Width and boundary rules:
- A requester dropping req_valid without a grant is legal, and its request is discarded.
- A requester whose req_valid stays high SHALL be granted within NUM_REQ cycles.
- rr_ptr wraps modulo NUM_REQ; for non-power-of-2 NUM_REQ it SHALL never hold a value >= NUM_REQ.

Reset
REQ-015 While RW0_rst is high at an edge, the following SHALL hold after that edge:
- rr_ptr=0.
- Issue register invalid; wrapper en=0.
- All pipeline stages invalid.
- rsp_valid=0, idle=1.
- req_ready=0 for the whole cycle RW0_rst is high.

REQ-016 Reset asserted mid-operation SHALL drop all in-flight reads with no response. An in-flight write not yet committed SHALL NOT be guaranteed to commit. Memory contents are not reset.

Structure
REQ-017 A package sram_arb_pkg SHALL hold the following, and the block SHALL import it:
- the constant RD_LAT=3;
- the requester-id typedef (width $clog2(NUM_REQ), minimum 1);
- the pipeline-entry struct {valid, id}.

REQ-018 sram_wrapper SHALL be the only sub-module. Arbitration, the issue register and the response pipeline SHALL be local logic.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single write/read: req0 writes addr 3 data 0xBEEF in cycle 10; req0 reads addr 3 in cycle 11 -> rsp_valid[0] high in cycle 14 only, rsp_rdata=0xBEEF.
- Contention, NUM_REQ=2: both valid continuously from cycle 0 after reset -> grants alternate 0,1,0,1, and each requester receives 50% of grants over 20 cycles.
- Back-to-back reads: 16 consecutive reads of addrs 0..15 after writing data=addr*0x0101 -> 16 consecutive responses with matching data, rsp_valid continuous for 16 cycles.
- Reset mid-flight: read granted in cycle G, RW0_rst high in cycle G+1 -> rsp_valid stays 0 through G+4, and idle=1 in cycle G+2.
- Fairness with wrap, NUM_REQ=3: rr_ptr=2, req0 and req2 valid -> req2 granted first, then req0.
- Idle tracking: single read -> idle low from G+1 through G+3, high from G+4.
